faddsub_pipe: RTL and testbench



---
 rtl/faddsub_pipe.sv | 181 ++++++++++++++++++
 tb/tb_faddsub_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/faddsub_pipe.sv
// faddsub_pipe: three-stage IEEE-754 adder/subtractor (RNE, gradual underflow), valid/ready on both sides.
// Optional build macro FADDSUB_FTZ_EN flushes subnormal inputs and results to signed zero.
module faddsub_pipe #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [EW+MW:0] x1,
    input  logic [EW+MW:0] x2,
    input  logic           op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [EW+MW:0] y,
    output logic           ovf
);
    localparam int W  = 1 + EW + MW;
    localparam int XW = MW + 4;                      // {hidden, frac, guard, round, sticky}
    localparam int CW = (EW + 1 > 7) ? EW + 1 : 7;   // holds any exponent or shift count
    localparam logic [EW-1:0] EMAX = '1;

    // Handshake: a beat moves when valid & ready; a held result stalls every stage together.
    logic stall;
    logic v1_q, v2_q, v3_q;
    assign stall     = v3_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v3_q;

    // ---------------- S1: unpack, order by magnitude, align ----------------
    logic            sa, sb, a_big, a_nan, b_nan;
    logic [EW-1:0]   ea, eb, eaf, ebf, esml;
    logic [MW:0]     ma, mb, mbig, msml;
    logic [CW-1:0]   ediff, sh;
    logic [2*MW+4:0] wide;
    logic            sbig_d, ssml_d, zs_d, sp_d;
    logic [EW-1:0]   ebig_d;
    logic [XW-1:0]   big_d, sml_d;
    logic [W-1:0]    spy_d;

    always_comb begin
        sa  = x1[W-1];
        sb  = x2[W-1] ^ op;
        ea  = x1[W-2:MW];
        eb  = x2[W-2:MW];
        ma  = {ea != '0, x1[MW-1:0]};
        mb  = {eb != '0, x2[MW-1:0]};
`ifdef FADDSUB_FTZ_EN
        if (ea == '0) ma = '0;
        if (eb == '0) mb = '0;
`endif
        eaf    = (ea == '0) ? EW'(1) : ea;
        ebf    = (eb == '0) ? EW'(1) : eb;
        a_big  = (eaf > ebf) || ((eaf == ebf) && (ma >= mb));
        ebig_d = a_big ? eaf : ebf;
        esml   = a_big ? ebf : eaf;
        mbig   = a_big ? ma : mb;
        msml   = a_big ? mb : ma;
        sbig_d = a_big ? sa : sb;
        ssml_d = a_big ? sb : sa;
        zs_d   = sa & sb;
        ediff  = CW'(ebig_d - esml);
        sh     = (ediff > CW'(XW)) ? CW'(XW) : ediff;
        wide   = {msml, {XW{1'b0}}} >> sh;
        sml_d  = {wide[2*MW+4:MW+2], |wide[MW+1:0]};
        big_d  = {mbig, 3'b000};

        a_nan = (ea == EMAX) && (x1[MW-1:0] != '0);
        b_nan = (eb == EMAX) && (x2[MW-1:0] != '0);
        sp_d  = (ea == EMAX) || (eb == EMAX);
        spy_d = '0;
        if (ea == EMAX && eb == EMAX) begin
            if (b_nan)         spy_d = {sb, EMAX, 1'b1, x2[MW-2:0]};
            else if (a_nan)    spy_d = {sa, EMAX, 1'b1, x1[MW-2:0]};
            else if (sa == sb) spy_d = {sa, EMAX, {MW{1'b0}}};
            else               spy_d = {1'b1, EMAX, 1'b1, {(MW-1){1'b0}}};
        end else if (ea == EMAX) begin
            spy_d = {sa, EMAX, x1[MW-1] | a_nan, x1[MW-2:0]};
        end else if (eb == EMAX) begin
            spy_d = {sb, EMAX, x2[MW-1] | b_nan, x2[MW-2:0]};
        end
    end

    logic            sb1_q, ss1_q, zs1_q, sp1_q;
    logic [EW-1:0]   e1_q;
    logic [XW-1:0]   big1_q, sml1_q;
    logic [W-1:0]    spy1_q;

    // ---------------- S2: add/subtract and normalise ----------------
    logic [XW:0]     sum;
    logic [CW-1:0]   lzc, e2c;
    logic [XW-2:0]   m2_d;
    logic [EW:0]     e2_d;
    logic            z2_d, uf2_d;

    always_comb begin
        sum = (sb1_q == ss1_q) ? ({1'b0, big1_q} + {1'b0, sml1_q})
                               : ({1'b0, big1_q} - {1'b0, sml1_q});
        lzc = CW'(XW);
        for (int i = 0; i < XW; i++) begin
            if (sum[i]) lzc = CW'(XW - 1 - i);
        end
        e2c   = CW'(e1_q);
        z2_d  = (sum == '0);
        uf2_d = 1'b0;
        m2_d  = sum[XW-2:0];
        e2_d  = {1'b0, e1_q};
        // m2_d drops the hidden bit: left shifts push the leading one out of the top.
        if (sum[XW]) begin
            m2_d = {sum[XW-1:2], sum[1] | sum[0]};
            e2_d = {1'b0, e1_q} + (EW+1)'(1);
        end else if (lzc < e2c) begin
            m2_d = sum[XW-2:0] << lzc;
            e2_d = {1'b0, e1_q} - (EW+1)'(lzc);
        end else begin
`ifdef FADDSUB_FTZ_EN
            uf2_d = 1'b1;
`else
            m2_d = sum[XW-2:0] << (e2c - CW'(1));
            e2_d = '0;
`endif
        end
    end

    logic            s2_q, zs2_q, z2_q, uf2_q, sp2_q;
    logic [EW:0]     e2_q;
    logic [XW-2:0]   m2_q;
    logic [W-1:0]    spy2_q;

    // ---------------- S3: round to nearest even and pack ----------------
    logic            rnd, ovf_d;
    logic [EW+MW:0]  ef;
    logic [W-1:0]    y_d;

    always_comb begin
        rnd   = m2_q[2] & (m2_q[1] | m2_q[0] | m2_q[3]);
        // Rounding carry ripples into the exponent field, which also lifts subnormals to normal.
        ef    = {e2_q, m2_q[XW-2:3]} + (EW+MW+1)'(rnd);
        y_d   = {s2_q, ef[EW+MW-1:0]};
        ovf_d = 1'b0;
        if (sp2_q) begin
            y_d = spy2_q;
        end else if (z2_q) begin
            y_d = {zs2_q, {(W-1){1'b0}}};
        end else if (uf2_q) begin
            y_d = {s2_q, {(W-1){1'b0}}};
        end else if (ef[EW+MW:MW] >= {1'b0, EMAX}) begin
            y_d   = {s2_q, EMAX, {MW{1'b0}}};
            ovf_d = 1'b1;
        end
    end

    logic [W-1:0] y_q;
    logic         ovf_q;
    assign y   = y_q;
    assign ovf = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;  sb1_q <= 1'b0;  ss1_q <= 1'b0;  zs1_q <= 1'b0;
            sp1_q  <= 1'b0;  e1_q  <= '0;    big1_q <= '0;   sml1_q <= '0;
            spy1_q <= '0;
            v2_q   <= 1'b0;  s2_q  <= 1'b0;  zs2_q <= 1'b0;  z2_q  <= 1'b0;
            uf2_q  <= 1'b0;  sp2_q <= 1'b0;  e2_q  <= '0;    m2_q  <= '0;
            spy2_q <= '0;
            v3_q   <= 1'b0;  y_q   <= '0;    ovf_q <= 1'b0;
        end else if (!stall) begin
            v1_q   <= in_valid;
            sb1_q  <= sbig_d;  ss1_q <= ssml_d;  zs1_q  <= zs_d;   sp1_q <= sp_d;
            e1_q   <= ebig_d;  big1_q <= big_d;  sml1_q <= sml_d;  spy1_q <= spy_d;
            v2_q   <= v1_q;
            s2_q   <= sb1_q;   zs2_q <= zs1_q;   z2_q  <= z2_d;    uf2_q <= uf2_d;
            sp2_q  <= sp1_q;   e2_q  <= e2_d;    m2_q  <= m2_d;    spy2_q <= spy1_q;
            v3_q   <= v2_q;
            y_q    <= y_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_faddsub_pipe.sv
// Bench for faddsub_pipe (binary32): directed vectors, backpressure, mid-run reset and
// randomized operands checked against an exact-arithmetic reference model.
module tb_faddsub_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op, out_valid, out_ready, ovf;
  logic [31:0] x1, x2, y;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [32:0] exp_q[$];

  faddsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: exact sum, then RNE ----------------
  // Operands become integers in units of 2^-149 so the sum is exact before rounding.
  function automatic logic [32:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic o);
    logic         sa, sb, s;
    logic [7:0]   ea, eb;
    logic [23:0]  ma, mb;
    logic [24:0]  q;
    logic [279:0] na, nb, n, rem, half;
    int p, k;
    sa = a[31]; sb = b[31] ^ o; ea = a[30:23]; eb = b[30:23];
    if (ea == 8'hFF || eb == 8'hFF) begin
      if (ea != 8'hFF) return {1'b0, sb, 8'hFF, b[22] | (b[22:0] != 0), b[21:0]};
      if (eb != 8'hFF) return {1'b0, sa, 8'hFF, a[22] | (a[22:0] != 0), a[21:0]};
      if (b[22:0] != 0) return {1'b0, sb, 8'hFF, 1'b1, b[21:0]};
      if (a[22:0] != 0) return {1'b0, sa, 8'hFF, 1'b1, a[21:0]};
      if (sa == sb) return {1'b0, sa, 8'hFF, 23'd0};
      return {1'b0, 32'hFFC00000};
    end
    ma = {ea != 0, a[22:0]};
    mb = {eb != 0, b[22:0]};
`ifdef FADDSUB_FTZ_EN
    if (ea == 0) ma = 0;
    if (eb == 0) mb = 0;
`endif
    na = 280'(ma) << ((ea == 0) ? 0 : int'(ea) - 1);
    nb = 280'(mb) << ((eb == 0) ? 0 : int'(eb) - 1);
    if (sa == sb) begin n = na + nb; s = sa; end
    else if (na >= nb) begin n = na - nb; s = sa; end
    else begin n = nb - na; s = sb; end
    if (n == 0) return {1'b0, sa & sb, 31'd0};
    p = 0;
    for (int i = 0; i < 280; i++) if (n[i]) p = i;
    if (p <= 23) begin
`ifdef FADDSUB_FTZ_EN
      if (p < 23) return {1'b0, s, 31'd0};
`endif
      return {1'b0, s, n[30:0]};
    end
    k    = p - 23;
    q    = 25'(n >> k);
    half = 280'(1) << (k - 1);
    rem  = n & ((280'(1) << k) - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q[24]) begin q = q >> 1; k = k + 1; end
    if (k + 1 >= 255) return {1'b1, s, 8'hFF, 23'd0};
    return {1'b0, s, 8'(k + 1), q[22:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_exp(input logic [31:0] a, input logic [31:0] b, input logic o, input logic [32:0] e);
    int n = 0;
    x1 = a; x2 = b; op = o; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    assert (in_ready === 1'b1) else begin
      failures++;
      $error("FAIL send_timeout got=%b exp=1", in_ready);
    end
    if (in_ready) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o);
    send_exp(a, b, o, ref_model(a, b, o));
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    #1;
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL drain_pending got=%0d exp=0", exp_q.size());
    end
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: v[22:0]  = 23'd0;
      3: v[30:23] = 8'hFE;
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [32:0] prev_out;
  logic        prev_stall = 1'b0;
  logic [32:0] e_item;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      checks++;
      assert (in_ready === !(out_valid && !out_ready)) else begin
        failures++;
        $error("FAIL in_ready got=%b exp=%b", in_ready, !(out_valid && !out_ready));
      end
      if (prev_stall) begin
        checks++;
        assert (out_valid === 1'b1 && {ovf, y} === prev_out) else begin
          failures++;
          $error("FAIL hold_stable got=%b/%h exp=1/%h", out_valid, {ovf, y}, prev_out);
        end
      end
      if (out_valid && out_ready) begin
        n_out++;
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_out got=%h exp=none", {ovf, y});
        end
        if (exp_q.size() != 0) begin
          e_item = exp_q.pop_front();
          checks++;
          assert ({ovf, y} === e_item) else begin
            failures++;
            $error("FAIL result got=%h exp=%h", {ovf, y}, e_item);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {ovf, y};
    end
  end

  // ---------------- directed and random sequence ----------------
  logic [31:0] da [9] = '{32'h3F800000, 32'h80000000, 32'h7F7FFFFF, 32'h7F800000, 32'h7FA00000,
                          32'h3F800000, 32'h3F800000, 32'h00000001, 32'hC0000000};
  logic [31:0] db [9] = '{32'h3F800000, 32'h80000000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000,
                          32'h33800000, 32'h33C00000, 32'h00000001, 32'h3F800000};
  logic        dop[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [32:0] dex[9] = '{33'h000000000, 33'h080000000, 33'h17F800000, 33'h0FFC00000, 33'h07FE00000,
                          33'h03F800000, 33'h03F800001,
`ifdef FADDSUB_FTZ_EN
                          33'h000000000,
`else
                          33'h000000002,
`endif
                          33'h0C0400000};
  logic done;

  initial begin
    int n, base;
    logic [31:0] a, b;
    rst = 1'b1; in_valid = 1'b0; x1 = '0; x2 = '0; op = 1'b0; out_ready = 1'b1; done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {32'd0, out_valid}, 33'd0);
    check("reset_y_ovf", {ovf, y}, 33'd0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", {32'd0, in_ready}, 33'd1);
    @(posedge clk); #1;

    // First op: exact latency from accept to out_valid.
    send_exp(32'h3F800000, 32'h40000000, 1'b0, 33'h040400000);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    check("latency", 33'(n), 33'd3);
    @(posedge clk); #1;
    drain();

    for (int i = 0; i < 9; i++) send_exp(da[i], db[i], dop[i], dex[i]);
    drain();

    // Backpressure: six back-to-back ops with the consumer stalled for four cycles.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) send(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 33'(n_out - base), 33'd6);

    // Reset with ops in flight: they must vanish.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_fp(), rand_fp(), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_out_valid", {32'd0, out_valid}, 33'd0);
    check("midreset_y_ovf", {ovf, y}, 33'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midreset_in_ready", {32'd0, in_ready}, 33'd1);
    base = n_out;
    repeat (6) @(posedge clk);
    #1;
    check("midreset_no_output", 33'(n_out - base), 33'd0);
    send(32'h40490FDB, 32'hC0490FDA, 1'b0);
    send(32'h00400000, 32'h00400000, 1'b0);
    drain();

    // Random operands with random consumer stalls and input gaps.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          a = rand_fp();
          case ($urandom_range(0, 3))
            0: begin b = rand_fp(); b[30:23] = a[30:23] + 8'($urandom_range(0, 2)) - 8'd1; end
            1: b = a ^ 32'($urandom_range(0, 15));
            default: b = rand_fp();
          endcase
          send(a, b, 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
